// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-cycle right shifter.
// Provides the FSM state type, the mode encodings and the width constants.
// It also provides the rem MSB helper, which the SHR_EARLY_EXIT_EN build uses.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shr_state_t;

  localparam logic MODE_SRL = 1'b0;
  localparam logic MODE_SRA = 1'b1;
  localparam int   XLEN     = 32;
  localparam int   SHW      = 5;

  // Index of the highest set bit of a shift amount.
  // The result is 0 for an all-zero input.
  function automatic logic [2:0] msb_idx(input logic [SHW-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < SHW; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/shift_right32_seq_shr_step.sv
// shr_step: combinational conditional right shift by 2^k.
// The vacated MSBs are filled with 'fill'. When en is low, d passes through unchanged.
module shr_step
  import alu_shift_pkg::*;
(
  input  logic [XLEN-1:0] d,
  input  logic [2:0]      k,
  input  logic            en,
  input  logic            fill,
  output logic [XLEN-1:0] q
);

  logic [5:0]        amt;
  logic [2*XLEN-1:0] ext;
  logic [XLEN-1:0]   shifted;

  // Prepend a word of fill bits, shift the whole thing, and keep the low word.
  assign amt     = 6'(1) << k;
  assign ext     = {{XLEN{fill}}, d};
  assign shifted = XLEN'(ext >> amt);

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
    assign q[gi] = en ? shifted[gi] : d[gi];
  end

endmodule

// File: rtl/shift_right32_seq.sv
// shift_right32_seq: multi-cycle 32-bit SRL/SRA.
// Each clock retires one power-of-two step. Operands arrive and results
// leave over valid/ready handshakes.
// Optional build macro: SHR_EARLY_EXIT_EN. When it is defined, the shifter
// visits only the set bits of the shift amount. Otherwise it always runs
// five steps, k = 4 down to 0.
module shift_right32_seq
  import alu_shift_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] inp,
  input  logic [SHW-1:0]  shamt,
  input  logic            mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  shr_state_t      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic            fill_q, fill_d;
  logic [2:0]      step_k;
  logic            step_en;
  logic [XLEN-1:0] step_q;

`ifdef SHR_EARLY_EXIT_EN
  // Step by the highest remaining set bit of rem.
  assign step_k  = msb_idx(rem_q);
  assign step_en = (state_q == SHIFT);
`else
  logic [2:0] k_q, k_d;
  // Walk k from 4 down to 0, shifting only where rem has a 1.
  assign step_k  = k_q;
  assign step_en = (state_q == SHIFT) && rem_q[k_q];
`endif

  shr_step u_step (
    .d    (acc_q),
    .k    (step_k),
    .en   (step_en),
    .fill (fill_q),
    .q    (step_q)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign res       = acc_q;

  // Next-state logic: accept in IDLE, shift in SHIFT, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
`ifndef SHR_EARLY_EXIT_EN
    k_d     = k_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          acc_d  = inp;
          rem_d  = shamt;
          fill_d = (mode == MODE_SRA) && inp[XLEN-1];
`ifdef SHR_EARLY_EXIT_EN
          state_d = (shamt == '0) ? DONE : SHIFT;
`else
          k_d     = 3'd4;
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        acc_d = step_q;
`ifdef SHR_EARLY_EXIT_EN
        rem_d = rem_q & ~(SHW'(1) << step_k);
        if (rem_d == '0) state_d = DONE;
`else
        k_d = k_q - 3'd1;
        if (k_q == 3'd0) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
`ifndef SHR_EARLY_EXIT_EN
      k_q     <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
`ifndef SHR_EARLY_EXIT_EN
      k_q     <= k_d;
`endif
    end
  end

endmodule
